// File: rtl/mqfu_sample_sequencer.sv
// Sample sequencer for the Madgwick quaternion filter core: streams IMU samples into the core,
// runs one update under a watchdog and returns the attitude quaternion on a result stream.
module mqfu_sample_sequencer #(
  parameter int unsigned ACC_WIDTH      = 16,
  parameter int unsigned Q_WIDTH        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [6*ACC_WIDTH-1:0] s_data_i,
  output logic [ACC_WIDTH-1:0]   core_a_x_o,
  output logic [ACC_WIDTH-1:0]   core_a_y_o,
  output logic [ACC_WIDTH-1:0]   core_a_z_o,
  output logic [ACC_WIDTH-1:0]   core_w_x_o,
  output logic [ACC_WIDTH-1:0]   core_w_y_o,
  output logic [ACC_WIDTH-1:0]   core_w_z_o,
  output logic                   core_start_o,
  input  logic                   core_done_i,
  input  logic [4*Q_WIDTH-1:0]   core_q_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [4*Q_WIDTH-1:0]   m_data_o,
  output logic                   busy_o,
  output logic                   irq_o,
  output logic                   err_timeout_o,
  output logic [CNT_WIDTH-1:0]   update_cnt_o,
  output logic [CNT_WIDTH-1:0]   timeout_cnt_o
);

  localparam int unsigned WdogW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StOut} state_e;

  state_e                 r_state, w_state_next;
  logic [WdogW-1:0]       r_wdog;
  logic [ACC_WIDTH-1:0]   r_ax, r_ay, r_az, r_wx, r_wy, r_wz;
  logic [4*Q_WIDTH-1:0]   r_m_data;
  logic                   r_irq;
  logic                   r_err;
  logic [CNT_WIDTH-1:0]   r_upd_cnt;
  logic [CNT_WIDTH-1:0]   r_to_cnt;

  logic w_accept, w_done_ok, w_timeout, w_handshake;

  assign w_accept    = (r_state == StIdle) && enable_i && s_valid_i;
  // Counter is zero only in the first WAIT cycle, which masks a stale level done.
  assign w_done_ok   = (r_state == StWait) && (r_wdog != '0) && core_done_i;
  assign w_timeout   = (r_state == StWait) && (r_wdog == WdogLast) && !w_done_ok;
  assign w_handshake = (r_state == StOut) && m_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StStart;
      StStart: w_state_next = StWait;
      StWait: begin
        if (w_done_ok)      w_state_next = StOut;
        else if (w_timeout) w_state_next = StIdle;
      end
      StOut:   if (w_handshake) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    s_ready_o    = (r_state == StIdle) && enable_i;
    core_start_o = (r_state == StStart);
    m_valid_o    = (r_state == StOut);
    busy_o       = (r_state != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wdog   <= '0;
      r_ax     <= '0;
      r_ay     <= '0;
      r_az     <= '0;
      r_wx     <= '0;
      r_wy     <= '0;
      r_wz     <= '0;
      r_m_data <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ax   <= s_data_i[0*ACC_WIDTH +: ACC_WIDTH];
        r_ay   <= s_data_i[1*ACC_WIDTH +: ACC_WIDTH];
        r_az   <= s_data_i[2*ACC_WIDTH +: ACC_WIDTH];
        r_wx   <= s_data_i[3*ACC_WIDTH +: ACC_WIDTH];
        r_wy   <= s_data_i[4*ACC_WIDTH +: ACC_WIDTH];
        r_wz   <= s_data_i[5*ACC_WIDTH +: ACC_WIDTH];
        r_wdog <= '0;
      end else if ((r_state == StWait) && (r_wdog != WdogLast)) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_done_ok) r_m_data <= core_q_i;
      r_irq <= w_handshake;
    end
  end

  // clear_i takes priority over any same-cycle increment or error set.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_err     <= 1'b0;
      r_upd_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      if (w_handshake) r_upd_cnt <= r_upd_cnt + 1'b1;
      if (w_timeout) begin
        r_err <= 1'b1;
        if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign core_a_x_o    = r_ax;
  assign core_a_y_o    = r_ay;
  assign core_a_z_o    = r_az;
  assign core_w_x_o    = r_wx;
  assign core_w_y_o    = r_wy;
  assign core_w_z_o    = r_wz;
  assign m_data_o      = r_m_data;
  assign irq_o         = r_irq;
  assign err_timeout_o = r_err;
  assign update_cnt_o  = r_upd_cnt;
  assign timeout_cnt_o = r_to_cnt;

endmodule
